// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous
// input in clk cycles, publishing one result per complete cycle.
module pwm_capture #(
  parameter int DUTY_W   = 12,
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Enable,
  input  logic                pwm_in,
  output logic [DUTY_W-1:0]   dutty,
  output logic [PERIOD_W-1:0] period,
  output logic                meas_valid,
  output logic                timeout
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [DUTY_W-1:0]   DUTY_MAX = '1;
  localparam logic [PERIOD_W-1:0] PER_MAX  = '1;
  localparam logic [DUTY_W-1:0]   DUTY_ONE = DUTY_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);

  state_t              state;
  logic [DUTY_W-1:0]   high_cnt;
  logic [PERIOD_W-1:0] per_cnt;
  logic                s1, s2, s3;
  logic                rise, fall, expired;

  // Both edges see the same three-cycle latency, so measured widths are exact.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // A saturated counter ends the measurement before it can wrap; this wins
  // over an edge arriving in the same cycle.
  assign expired = ((state == HIGH) && (high_cnt == DUTY_MAX)) ||
                   ((state != IDLE) && (per_cnt == PER_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      high_cnt   <= '0;
      per_cnt    <= '0;
      dutty      <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!Enable) begin
        state    <= IDLE;
        high_cnt <= '0;
        per_cnt  <= '0;
      end else if (expired) begin
        timeout  <= 1'b1;
        state    <= IDLE;
        high_cnt <= '0;
        per_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state    <= HIGH;
              high_cnt <= DUTY_ONE;
              per_cnt  <= PER_ONE;
            end
          end
          HIGH: begin
            per_cnt <= per_cnt + PER_ONE;
            if (fall) begin
              state <= LOW;
            end else begin
              high_cnt <= high_cnt + DUTY_ONE;
            end
          end
          LOW: begin
            if (rise) begin
              dutty      <= high_cnt;
              period     <= per_cnt;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              state      <= HIGH;
              high_cnt   <= DUTY_ONE;
              per_cnt    <= PER_ONE;
            end else begin
              per_cnt <= per_cnt + PER_ONE;
            end
          end
          default: begin
            state    <= IDLE;
            high_cnt <= '0;
            per_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus randomized pulse trains,
// checked against a pulse-level model of rise-to-rise measurements.
module tb_pwm_capture;

  // Narrow widths keep the saturation scenarios within a short run.
  localparam int DW   = 8;
  localparam int PW   = 12;
  localparam int DMAX = (1 << DW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pwm_in = 1'b0;
  logic [DW-1:0] dutty;
  logic [PW-1:0] period;
  logic          meas_valid;
  logic          timeout;

  always #5 clk = ~clk;

  pwm_capture #(.DUTY_W(DW), .PERIOD_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Enable     (enable),
    .pwm_in     (pwm_in),
    .dutty      (dutty),
    .period     (period),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse-level model: each pulse is (high cycles, low cycles) starting with a
  // rise; a result is owed at the next rise if the pulse was measured cleanly.
  typedef struct {
    int duty;
    int per;
  } meas_t;

  meas_t exp_q[$];
  bit    counting = 1'b0;
  bit    swallow_next = 1'b0;
  int    pend_h = 0;
  int    pend_p = 0;
  int    exp_duty = 0;
  int    exp_per = 0;
  int    exp_to = 0;
  int    obs_to = 0;
  int    n_valid = 0;
  int    nv0 = 0;

  function automatic void model_rise(input int h, input int l);
    meas_t m;
    if (swallow_next) begin
      // The rise landing on the saturating cycle is lost to the timeout.
      swallow_next = 1'b0;
      counting     = 1'b0;
      return;
    end
    if (counting) begin
      m.duty = pend_h;
      m.per  = pend_p;
      exp_q.push_back(m);
      exp_duty = pend_h;
      exp_per  = pend_p;
    end
    counting = 1'b1;
    pend_h   = h;
    pend_p   = h + l;
    if (h >= DMAX || h + l >= PMAX) begin
      counting = 1'b0;
      exp_to++;
      swallow_next = (h < DMAX) && (h + l == PMAX);
    end
  endfunction

  task automatic drive(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    model_rise(h, l);
    drive(h, l);
  endtask

  // Result monitor: every strobe must match the oldest owed result.
  logic  to_prev = 1'b0;
  meas_t got;
  always @(negedge clk) begin
    if (timeout === 1'b1 && to_prev !== 1'b1) obs_to++;
    to_prev = timeout;
    if (meas_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", meas_valid, 0);
      end else begin
        got = exp_q.pop_front();
        check("dutty", dutty, got.duty);
        check("period", period, got.per);
        check("timeout_clear", timeout, 0);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dutty", dutty, 0);
    check("rst_period", period, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Steady 100/1000 waveform.
    repeat (4) pulse(100, 900);
    check("steady_count", n_valid, 3);
    check("steady_dutty", dutty, 100);
    check("steady_period", period, 1000);

    // Enable arrives mid-pulse: the partial pulse must not be measured.
    enable   = 1'b0;
    counting = 1'b0;
    pwm_in   = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    repeat (80) @(negedge clk);
    pwm_in = 1'b0;
    repeat (400) @(negedge clk);
    nv0 = n_valid;
    pulse(100, 900);
    check("partial_ignored", n_valid, nv0);
    pulse(100, 900);
    check("first_clean", n_valid, nv0 + 1);

    // Input stuck low after a rise/fall pair: period saturates.
    model_rise(100, 5000);
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3997) @(negedge clk);
    check("low_to_before", timeout, 0);
    @(negedge clk);
    check("low_to_at", timeout, 1);
    check("low_to_valid", meas_valid, 0);
    check("low_hold_dutty", dutty, exp_duty);
    check("low_hold_period", period, exp_per);
    nv0 = n_valid;
    pulse(100, 900);
    pulse(100, 900);
    check("resume_count", n_valid, nv0 + 1);
    check("resume_to_clear", timeout, 0);

    // Input stuck high: high time saturates and the next rise starts afresh.
    model_rise(300, 200);
    pwm_in = 1'b1;
    repeat (257) @(negedge clk);
    check("high_to_before", timeout, 0);
    @(negedge clk);
    check("high_to_at", timeout, 1);
    repeat (42) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    nv0 = n_valid;
    pulse(100, 900);
    check("high_to_idle", n_valid, nv0);
    pulse(100, 900);

    // Waveform change between cycles, including one mixed cycle.
    pulse(150, 900);
    pulse(150, 1850);
    pulse(150, 1850);
    pulse(150, 1850);
    check("new_dutty", dutty, 150);
    check("new_period", period, 2000);

    // Enable drop mid-period: nothing published, outputs hold.
    model_rise(100, 900);
    drive(100, 400);
    enable   = 1'b0;
    counting = 1'b0;
    nv0      = n_valid;
    repeat (100) @(negedge clk);
    check("en_drop_count", n_valid, nv0);
    check("en_hold_dutty", dutty, exp_duty);
    check("en_hold_period", period, exp_per);
    check("en_hold_timeout", timeout, 0);
    enable = 1'b1;
    repeat (400) @(negedge clk);
    pulse(100, 900);
    pulse(100, 900);

    // Reset mid-period clears everything on the next edge.
    model_rise(100, 900);
    drive(100, 400);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_dutty", dutty, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_valid", meas_valid, 0);
    check("mid_rst_timeout", timeout, 0);
    rst_n    = 1'b1;
    counting = 1'b0;
    exp_duty = 0;
    exp_per  = 0;
    repeat (500) @(negedge clk);

    // Boundary pulses around the saturation points, then random trains.
    pulse(1, 1);
    pulse(254, 1);
    pulse(255, 5);
    pulse(20, 4074);
    pulse(20, 4075);
    pulse(30, 100);
    pulse(1, 1);
    for (int i = 0; i < 30; i++) begin
      pulse(int'($urandom_range(1, 60)), int'($urandom_range(1, 300)));
    end
    pulse(10, 10);
    repeat (10) @(negedge clk);

    check("owed_results", exp_q.size(), 0);
    check("timeout_events", obs_to, exp_to);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
